link_bringup_ctrl: RTL and testbench

Sequences bring-up of one 10G SFP lane: fPLL power-down/lock, GX reset controller release, then PCS TX/RX reset release and block-lock qualification. In UP it monitors link health and drives a full retrain when the link fails. Sits between the transceiver reset controller/fPLL and pcs_rx/pcs_tx, in the logic_clk domain. All inputs arrive already synchronised to clk.

---
 rtl/link_ctrl_pkg.sv | 42 ++++
 rtl/link_err_mon.sv | 54 +++++
 rtl/link_bringup_ctrl.sv | 130 +++++++++++++
 tb/tb_link_bringup_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/link_ctrl_pkg.sv
// Shared types for the 10G lane bring-up controller: state encoding,
// retrain counter width and the per-state output decode.
package link_ctrl_pkg;

  localparam int unsigned RETRAIN_W = 8;

  typedef enum logic [2:0] {
    ST_PD        = 3'd0,
    ST_PLL_WAIT  = 3'd1,
    ST_PHY_WAIT  = 3'd2,
    ST_LOCK_WAIT = 3'd3,
    ST_UP        = 3'd4,
    ST_FAIL      = 3'd5
  } link_state_e;

  typedef struct packed {
    logic pll_pd;
    logic phy_rst;
    logic pcs_tx_nrst;
    logic pcs_rx_nrst;
    logic link_up;
  } link_ctrl_t;

  function automatic link_ctrl_t decode_state(input link_state_e s);
    link_ctrl_t c;
    c = '{pll_pd: 1'b1, phy_rst: 1'b1, pcs_tx_nrst: 1'b0, pcs_rx_nrst: 1'b0, link_up: 1'b0};
    case (s)
      ST_PLL_WAIT:  c.pll_pd = 1'b0;
      ST_PHY_WAIT:  begin c.pll_pd = 1'b0; c.phy_rst = 1'b0; end
      ST_LOCK_WAIT: begin
        c.pll_pd = 1'b0; c.phy_rst = 1'b0; c.pcs_tx_nrst = 1'b1; c.pcs_rx_nrst = 1'b1;
      end
      ST_UP: begin
        c.pll_pd = 1'b0; c.phy_rst = 1'b0; c.pcs_tx_nrst = 1'b1; c.pcs_rx_nrst = 1'b1;
        c.link_up = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/link_err_mon.sv
// Windowed error monitor: flags when ERR_MAX errors land inside one
// ERR_WIN-cycle window while enabled.
module link_err_mon #(
  parameter int unsigned ERR_WIN = 8192,
  parameter int unsigned ERR_MAX = 16
) (
  input  logic clk,
  input  logic nreset,
  input  logic en,
  input  logic clr,
  input  logic err,
  output logic thresh_o
);

  localparam int unsigned WIN_W = ($clog2(ERR_WIN) > 0) ? $clog2(ERR_WIN) : 1;
  localparam int unsigned CNT_W = $clog2(ERR_MAX + 1);

  logic [WIN_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             win_end;

  // Kept outside the counter process so the controller's next-state logic
  // (which feeds clr) never sees a combinational loop through this block.
  assign thresh_o = en && err && (cnt_q == CNT_W'(ERR_MAX - 1));
  assign win_end  = (win_q == WIN_W'(ERR_WIN - 1));

  always_comb begin
    win_d = win_q;
    cnt_d = cnt_q;
    if (clr) begin
      win_d = '0;
      cnt_d = '0;
    end else if (en) begin
      if (win_end) begin
        win_d = '0;
        cnt_d = '0;
      end else begin
        win_d = win_q + 1'b1;
        if (err) cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      win_q <= '0;
      cnt_q <= '0;
    end else begin
      win_q <= win_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/link_bringup_ctrl.sv
// Bring-up and health sequencer for one 10G SFP lane: fPLL, GX reset
// controller, PCS resets, block-lock qualification and retrain on failure.
module link_bringup_ctrl
  import link_ctrl_pkg::*;
#(
  parameter int unsigned PD_CYCLES    = 64,
  parameter int unsigned PLL_TIMEOUT  = 65536,
  parameter int unsigned PHY_TIMEOUT  = 65536,
  parameter int unsigned LOCK_TIMEOUT = 262144,
  parameter int unsigned LOCK_STABLE  = 64,
  parameter int unsigned ERR_WIN      = 8192,
  parameter int unsigned ERR_MAX      = 16
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 pll_locked_i,
  input  logic                 tx_ready_i,
  input  logic                 rx_ready_i,
  input  logic                 rx_signal_v_i,
  input  logic                 rx_valid_i,
  input  logic                 rx_err_v_i,
  output logic                 pll_powerdown_o,
  output logic                 phy_rst_o,
  output logic                 pcs_tx_nreset_o,
  output logic                 pcs_rx_nreset_o,
  output logic                 link_up_o,
  output logic [RETRAIN_W-1:0] retrain_cnt_o,
  output logic [2:0]           state_o
);

  localparam int unsigned MAX_A  = (PLL_TIMEOUT > PHY_TIMEOUT) ? PLL_TIMEOUT : PHY_TIMEOUT;
  localparam int unsigned MAX_B  = (MAX_A > LOCK_TIMEOUT) ? MAX_A : LOCK_TIMEOUT;
  localparam int unsigned MAX_TO = (MAX_B > PD_CYCLES) ? MAX_B : PD_CYCLES;
  localparam int unsigned TMR_W  = $clog2(MAX_TO) + 1;
  localparam int unsigned STB_W  = $clog2(LOCK_STABLE + 1);

  link_state_e          state_q, state_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [STB_W-1:0]     stable_q, stable_d;
  logic [RETRAIN_W-1:0] retrain_q, retrain_d;
  link_ctrl_t           ctrl_q, ctrl_d;

  logic links_ok, stable_done, err_thresh, mon_en, mon_clr;

  assign links_ok    = pll_locked_i & tx_ready_i & rx_ready_i;
  assign stable_done = rx_signal_v_i && (stable_q == STB_W'(LOCK_STABLE - 1));
  assign mon_en      = (state_q == ST_UP);
  assign mon_clr     = (state_d == ST_UP) && (state_q != ST_UP);

  link_err_mon #(
    .ERR_WIN (ERR_WIN),
    .ERR_MAX (ERR_MAX)
  ) u_err_mon (
    .clk      (clk),
    .nreset   (nreset),
    .en       (mon_en),
    .clr      (mon_clr),
    .err      (rx_valid_i & rx_err_v_i),
    .thresh_o (err_thresh)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_PD:        if (timer_q == TMR_W'(PD_CYCLES - 1)) state_d = ST_PLL_WAIT;
      ST_PLL_WAIT: begin
        if (pll_locked_i)                              state_d = ST_PHY_WAIT;
        else if (timer_q == TMR_W'(PLL_TIMEOUT - 1))   state_d = ST_FAIL;
      end
      ST_PHY_WAIT: begin
        if (!pll_locked_i)                             state_d = ST_FAIL;
        else if (tx_ready_i && rx_ready_i)             state_d = ST_LOCK_WAIT;
        else if (timer_q == TMR_W'(PHY_TIMEOUT - 1))   state_d = ST_FAIL;
      end
      ST_LOCK_WAIT: begin
        if (!links_ok)                                 state_d = ST_FAIL;
        else if (stable_done)                          state_d = ST_UP;
        else if (timer_q == TMR_W'(LOCK_TIMEOUT - 1))  state_d = ST_FAIL;
      end
      ST_UP: begin
        if (!links_ok)                                 state_d = ST_FAIL;
        else if (err_thresh)                           state_d = ST_FAIL;
        else if (!rx_signal_v_i)                       state_d = ST_LOCK_WAIT;
      end
      ST_FAIL:      state_d = ST_PD;
      default:      state_d = ST_PD;
    endcase

    if (state_d != state_q)  timer_d = '0;
    else if (timer_q != '1)  timer_d = timer_q + 1'b1;
    else                     timer_d = timer_q;

    stable_d = '0;
    if ((state_q == ST_LOCK_WAIT) && (state_d == ST_LOCK_WAIT) && rx_signal_v_i)
      stable_d = stable_q + 1'b1;

    retrain_d = retrain_q;
    if ((state_d == ST_FAIL) && (state_q != ST_FAIL) && (retrain_q != '1))
      retrain_d = retrain_q + 1'b1;

    // Outputs are decoded from the next state and registered, so they
    // switch on the same edge that enters the state.
    ctrl_d = decode_state(state_d);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q   <= ST_PD;
      timer_q   <= '0;
      stable_q  <= '0;
      retrain_q <= '0;
      ctrl_q    <= decode_state(ST_PD);
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      stable_q  <= stable_d;
      retrain_q <= retrain_d;
      ctrl_q    <= ctrl_d;
    end
  end

  assign pll_powerdown_o = ctrl_q.pll_pd;
  assign phy_rst_o       = ctrl_q.phy_rst;
  assign pcs_tx_nreset_o = ctrl_q.pcs_tx_nrst;
  assign pcs_rx_nreset_o = ctrl_q.pcs_rx_nrst;
  assign link_up_o       = ctrl_q.link_up;
  assign retrain_cnt_o   = retrain_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_link_bringup_ctrl.sv
// Self-checking bench for link_bringup_ctrl: vector table, directed corner
// sequences and biased random stimulus against a cycle-count reference model.
module tb_link_bringup_ctrl;

  localparam int PD_CYCLES = 4, PLL_TO = 16, PHY_TO = 16, LOCK_TO = 32;
  localparam int LOCK_STABLE = 4, ERR_WIN = 16, ERR_MAX = 3;
  localparam int PH_PD = 0, PH_PLL = 1, PH_PHY = 2, PH_LOCK = 3, PH_UP = 4, PH_FAIL = 5;
  localparam logic [15:0] RST_VEC = {5'b11000, 8'd0, 3'd0};

  logic clk = 1'b0;
  logic nreset = 1'b0;
  logic pll = 1'b0, txr = 1'b0, rxr = 1'b0, sig = 1'b0, val = 1'b0, errv = 1'b0;
  logic pd, phy, txn, rxn, up;
  logic [7:0] rcnt;
  logic [2:0] st;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  link_bringup_ctrl #(
    .PD_CYCLES    (PD_CYCLES),
    .PLL_TIMEOUT  (PLL_TO),
    .PHY_TIMEOUT  (PHY_TO),
    .LOCK_TIMEOUT (LOCK_TO),
    .LOCK_STABLE  (LOCK_STABLE),
    .ERR_WIN      (ERR_WIN),
    .ERR_MAX      (ERR_MAX)
  ) dut (
    .clk             (clk),
    .nreset          (nreset),
    .pll_locked_i    (pll),
    .tx_ready_i      (txr),
    .rx_ready_i      (rxr),
    .rx_signal_v_i   (sig),
    .rx_valid_i      (val),
    .rx_err_v_i      (errv),
    .pll_powerdown_o (pd),
    .phy_rst_o       (phy),
    .pcs_tx_nreset_o (txn),
    .pcs_rx_nreset_o (rxn),
    .link_up_o       (up),
    .retrain_cnt_o   (rcnt),
    .state_o         (st)
  );

  // Reference model: phase plus elapsed-cycle counts derived from the rules.
  int m_ph, m_t, m_run, m_upc, m_errs, m_retrain;

  task automatic model_reset();
    m_ph = PH_PD; m_t = 0; m_run = 0; m_upc = 0; m_errs = 0; m_retrain = 0;
  endtask

  task automatic model_step();
    int nxt, run_now;
    bit ok, e;
    ok = pll && txr && rxr;
    e = val && errv;
    run_now = sig ? m_run + 1 : 0;
    nxt = m_ph;
    case (m_ph)
      PH_PD:   if (m_t + 1 >= PD_CYCLES) nxt = PH_PLL;
      PH_PLL:  if (pll) nxt = PH_PHY; else if (m_t + 1 >= PLL_TO) nxt = PH_FAIL;
      PH_PHY:  if (!pll) nxt = PH_FAIL; else if (txr && rxr) nxt = PH_LOCK;
               else if (m_t + 1 >= PHY_TO) nxt = PH_FAIL;
      PH_LOCK: if (!ok) nxt = PH_FAIL; else if (run_now >= LOCK_STABLE) nxt = PH_UP;
               else if (m_t + 1 >= LOCK_TO) nxt = PH_FAIL;
      PH_UP:   if (!ok) nxt = PH_FAIL; else if (e && m_errs + 1 >= ERR_MAX) nxt = PH_FAIL;
               else if (!sig) nxt = PH_LOCK;
      default: nxt = PH_PD;
    endcase
    if (m_ph == PH_UP) begin
      if ((m_upc % ERR_WIN) == ERR_WIN - 1) m_errs = 0;
      else m_errs += int'(e);
      m_upc++;
    end
    m_run = (m_ph == PH_LOCK) ? run_now : 0;
    if (nxt != m_ph) begin
      m_t = 0;
      if (nxt == PH_FAIL && m_retrain < 255) m_retrain++;
      if (nxt == PH_UP) begin m_upc = 0; m_errs = 0; end
    end else begin
      m_t++;
    end
    m_ph = nxt;
  endtask

  function automatic logic [15:0] model_vec();
    logic pd_e, phy_e, pcs_e, up_e;
    pd_e  = (m_ph == PH_PD) || (m_ph == PH_FAIL);
    phy_e = pd_e || (m_ph == PH_PLL);
    pcs_e = (m_ph == PH_LOCK) || (m_ph == PH_UP);
    up_e  = (m_ph == PH_UP);
    return {pd_e, phy_e, pcs_e, pcs_e, up_e, 8'(m_retrain), 3'(m_ph)};
  endfunction

  function automatic logic [15:0] dut_vec();
    return {pd, phy, txn, rxn, up, rcnt, st};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic set_in(input logic p, input logic t, input logic r, input logic s,
                        input logic v, input logic e);
    pll = p; txr = t; rxr = r; sig = s; val = v; errv = e;
  endtask

  task automatic cycle(input string name);
    model_step();
    @(posedge clk);
    #1;
    check(name, 32'(dut_vec()), 32'(model_vec()));
  endtask

  // Called at posedge+1: asserts reset between edges and checks it took effect asynchronously.
  task automatic do_reset(input string name);
    nreset = 1'b0;
    #1;
    check(name, 32'(dut_vec()), 32'(RST_VEC));
    model_reset();
    set_in(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    nreset = 1'b1;
  endtask

  task automatic bring_up();
    set_in(1, 1, 1, 1, 0, 0);
    for (int i = 0; i < 60; i++) begin
      cycle("bring_up");
      if (st == 3'(PH_UP)) break;
    end
    check("bring_up_reached", 32'(st), 32'(PH_UP));
  endtask

  task automatic bring_to_lock();
    set_in(1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 60; i++) begin
      cycle("to_lock");
      if (st == 3'(PH_LOCK)) break;
    end
    check("lock_wait_reached", 32'(st), 32'(PH_LOCK));
  endtask

  typedef struct {
    logic p, t, r, s;
    int   n;
    logic [2:0] st;
    logic up, pcs, pd;
    logic [7:0] rc;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(input logic p, input logic t, input logic r, input logic s,
                              input int n, input logic [2:0] xs, input logic xu,
                              input logic xpcs, input logic xpd, input logic [7:0] xrc);
    vec_t v;
    v.p = p; v.t = t; v.r = r; v.s = s; v.n = n;
    v.st = xs; v.up = xu; v.pcs = xpcs; v.pd = xpd; v.rc = xrc;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Nominal bring-up, UP->LOCK_WAIT on signal drop, FAIL on rx_ready loss.
    tbl[0]  = mk(0, 0, 0, 0, 4, 3'd1, 0, 0, 0, 8'd0);
    tbl[1]  = mk(0, 0, 0, 0, 6, 3'd1, 0, 0, 0, 8'd0);
    tbl[2]  = mk(1, 0, 0, 0, 1, 3'd2, 0, 0, 0, 8'd0);
    tbl[3]  = mk(1, 0, 0, 0, 3, 3'd2, 0, 0, 0, 8'd0);
    tbl[4]  = mk(1, 1, 1, 0, 1, 3'd3, 0, 1, 0, 8'd0);
    tbl[5]  = mk(1, 1, 1, 0, 1, 3'd3, 0, 1, 0, 8'd0);
    tbl[6]  = mk(1, 1, 1, 1, 3, 3'd3, 0, 1, 0, 8'd0);
    tbl[7]  = mk(1, 1, 1, 1, 1, 3'd4, 1, 1, 0, 8'd0);
    tbl[8]  = mk(1, 1, 1, 1, 5, 3'd4, 1, 1, 0, 8'd0);
    tbl[9]  = mk(1, 1, 1, 0, 1, 3'd3, 0, 1, 0, 8'd0);
    tbl[10] = mk(1, 1, 1, 1, 3, 3'd3, 0, 1, 0, 8'd0);
    tbl[11] = mk(1, 1, 1, 1, 1, 3'd4, 1, 1, 0, 8'd0);
    tbl[12] = mk(1, 1, 0, 1, 1, 3'd5, 0, 0, 1, 8'd1);
    tbl[13] = mk(0, 0, 0, 0, 1, 3'd0, 0, 0, 1, 8'd1);
    tbl[14] = mk(0, 0, 0, 0, 4, 3'd1, 0, 0, 0, 8'd1);

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'(dut_vec()), 32'(RST_VEC));
    nreset = 1'b1;

    for (int r = 0; r < 15; r++) begin
      set_in(tbl[r].p, tbl[r].t, tbl[r].r, tbl[r].s, 0, 0);
      for (int k = 0; k < tbl[r].n; k++) cycle("nominal");
      check($sformatf("table_row%0d", r), 32'({st, up, txn & rxn, pd, rcnt}),
            32'({tbl[r].st, tbl[r].up, tbl[r].pcs, tbl[r].pd, tbl[r].rc}));
    end

    // PLL never locks: FAIL after 4 PD + 16 PLL_WAIT cycles, three attempts.
    do_reset("reset_pll");
    for (int i = 0; i < 19; i++) cycle("pll_none");
    check("pll_wait_last_cycle", 32'(st), 32'(PH_PLL));
    cycle("pll_none");
    check("pll_timeout_fail", 32'({st, rcnt}), 32'({3'd5, 8'd1}));
    cycle("pll_none");
    check("pd_reasserted", 32'({st, pd}), 32'({3'd0, 1'b1}));
    for (int i = 0; i < 41; i++) cycle("pll_none");
    check("three_attempts", 32'({st, rcnt}), 32'({3'd5, 8'd3}));

    // Lock flicker: only the final 4-run qualifies.
    do_reset("reset_flicker");
    bring_to_lock();
    begin
      int pat[8] = '{1, 1, 1, 0, 1, 1, 1, 1};
      for (int i = 0; i < 8; i++) begin
        sig = pat[i][0];
        cycle("flicker");
        check($sformatf("flicker_%0d", i), 32'(st), (i == 7) ? 32'(PH_UP) : 32'(PH_LOCK));
      end
    end

    // Signal never stable: LOCK_WAIT times out after 32 cycles.
    do_reset("reset_unstable");
    bring_to_lock();
    for (int i = 0; i < 32; i++) begin
      sig = (i % 4) != 3;
      cycle("unstable");
      if (i == 30) check("lock_wait_cycle31", 32'(st), 32'(PH_LOCK));
    end
    check("lock_timeout_fail", 32'(st), 32'(PH_FAIL));

    // Three errors in one window -> FAIL on the third.
    do_reset("reset_err3");
    bring_up();
    for (int i = 0; i < 3; i++) begin
      set_in(1, 1, 1, 1, 1, 1);
      cycle("err3");
      check($sformatf("err3_%0d", i), 32'(st), (i == 2) ? 32'(PH_FAIL) : 32'(PH_UP));
    end

    // Two errors per window over four windows, plus unqualified err_v -> stays UP.
    do_reset("reset_err2");
    bring_up();
    for (int k = 0; k < 64; k++) begin
      set_in(1, 1, 1, 1, (k % 16) != 12, (k % 16) == 3 || (k % 16) == 9 || (k % 16) == 12);
      cycle("err2win");
    end
    check("err2_stays_up", 32'({st, up}), 32'({3'd4, 1'b1}));

    // Third error on the window-end cycle -> threshold wins.
    do_reset("reset_errend");
    bring_up();
    for (int k = 0; k < 16; k++) begin
      set_in(1, 1, 1, 1, 1, (k == 0) || (k == 1) || (k == 15));
      cycle("err_win_end");
      if (k == 14) check("err_before_end", 32'(st), 32'(PH_UP));
    end
    check("err_on_window_end", 32'({st, rcnt}), 32'({3'd5, 8'd1}));

    // Async reset while UP loses the retrain count.
    bring_up();
    check("retrain_before_reset", 32'({st, rcnt}), 32'({3'd4, 8'd1}));
    do_reset("async_reset_in_up");

    // 300 forced failures saturate the retrain counter.
    for (int i = 0; i < 300 * 21; i++) cycle("saturate");
    check("retrain_saturated", 32'(rcnt), 32'd255);

    // Biased random stimulus against the model.
    do_reset("reset_random");
    for (int i = 0; i < 3000; i++) begin
      set_in($urandom_range(99) < 97, $urandom_range(99) < 96, $urandom_range(99) < 96,
             $urandom_range(99) < 88, $urandom_range(99) < 80, $urandom_range(99) < 12);
      cycle("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
